bus_arbiter16: RTL and testbench
================================

Name: bus_arbiter16

Overview:
Round-robin arbiter that shares one 16-bit output bus among NREQ requesters. It drives the select of a 16-bit mux tree built from the existing 16-bit 2:1 mux primitive. A valid/ready handshake runs on the shared side, and a burst-hold limit guarantees fairness. It sits between datapath producers (ALU result, register read, memory read) and a single shared consumer bus.

Parameters:
NREQ, 4, number of requesters; power of two, 2..8.
DW, 16, data width per requester; fixed at 16 for mux-tree reuse.
MAX_HOLD, 8, accepted beats after which the owner must yield if another requester is waiting; must be at least 1.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
req  in  NREQ  per-requester request; bit i high means data_in slice i is valid.
data_in  in  NREQ*DW  packed requester data; slice i is bits [i*16+15 : i*16].
out_ready  in  1  consumer accepts the beat this cycle.
grant  out  NREQ  one-hot owner; all zero when idle.
sel  out  $clog2(NREQ)  encoded owner index; mux-tree select.
out_data  out  DW  data of the owner, taken combinationally through the mux tree.
out_valid  out  1  owner has a beat on out_data.
busy  out  1  high in GRANT state.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, grant=0, sel=0, busy=0, hold_cnt=0, last=NREQ-1. With last=NREQ-1, requester 0 has top priority first.
- out_valid = (state==GRANT) & req[sel]. out_data = data_in slice selected by sel, and is driven even when out_valid=0. Both are combinational from registered sel.
- A beat is accepted when out_valid & out_ready are both high.
- States: IDLE, GRANT.
  - IDLE: if any req bit is high, pick the first set bit scanning last+1, last+2, … with wrap modulo NREQ.
  - On that pick, at the next edge: grant=onehot(pick), sel=pick, last=pick, hold_cnt=0, state=GRANT.
  - Latency from req rising in IDLE to grant: 1 cycle.
  - No req in IDLE: remain in IDLE, outputs unchanged (grant=0).
- GRANT, owner drops req[sel] (no beat possible that cycle): next edge goes to IDLE with grant=0. One dead cycle follows before any re-grant.
- GRANT, beat accepted: hold_cnt increments.
  - If hold_cnt==MAX_HOLD-1 and any other req bit is high: next edge goes to IDLE, grant=0 (forced yield).
  - If hold_cnt==MAX_HOLD-1 and no other req bit is high: hold_cnt wraps to 0 and the owner keeps the grant.
- GRANT, owner stalled (out_valid=1, out_ready=0): hold_cnt unchanged, owner retained. The requester must hold data stable while req=1 and no beat is accepted.
- Simultaneous yield condition and owner req drop: not possible in the same cycle, because the yield requires an accepted beat, which requires req high.
- New requests from others while GRANT is active: queued implicitly; they are not observed until IDLE.
- Yield rotation: after a forced yield, the former owner is last in priority order for the next pick.
- rst_n asserted mid-burst: all outputs go to reset values immediately (asynchronous). A beat being presented is dropped, with no partial acceptance.
- hold_cnt width: $clog2(MAX_HOLD), minimum 1 bit.

Decomposition:
- defs.h: state encodings `ARB_IDLE=1'b0 and `ARB_GRANT=1'b1, plus default NREQ/MAX_HOLD defines.
- Sub-module rr_picker: purely combinational. Inputs are req and last; outputs are a pick index and an any flag. It is instantiated once.
- The data mux tree is built from the existing 16-bit 2:1 mux primitive, using log2(NREQ) levels keyed on sel bits.
- FSM, hold counter and grant registers stay in bus_arbiter16.

Test Plan:
- Reset then req=0001, data0=16'hAAAA, out_ready=1 → grant=0001 at cycle+1; out_valid=1 and out_data=AAAA each cycle while req held.
- req=1111 from reset, each requester drops req after 1 accepted beat → grants in order 0001, 0010, 0100, 1000, each separated by one idle cycle.
- req=0011, out_ready=1, MAX_HOLD=8 → requester 0 gets exactly 8 beats, then one idle cycle, then grant=0010.
- req=0001 alone for 20 beats → grant stays 0001 throughout; hold_cnt wraps with no idle cycle inserted.
- Owner stall: grant=0001, out_ready=0 for 5 cycles with data0=1234 → out_valid=1, out_data=1234 stable, hold_cnt unchanged, no yield.
- rst_n pulsed low mid-burst while grant=0100 → grant=0 and out_valid=0 immediately. After release with req=0100 → grant=0100 one cycle later (priority restarts at requester 0; 0100 is the only requester).

Source files
------------

// File: rtl/bus_arbiter16_pkg.sv
// ----------------------------------------------------------------------------
// bus_arbiter16_pkg: shared state encoding, defaults and width helper.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_arbiter16_pkg;

  localparam int ARB_DW       = 16;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Width of an index/counter covering v values, never narrower than 1 bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter16_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker: combinational round-robin pick starting after index 'last'.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_picker
  import bus_arbiter16_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int SW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   last,
  output logic [SW-1:0]   pick,
  output logic            any
);

  // Scan farthest offset first so the nearest set bit after 'last' wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        pick = SW'((int'(last) + k) % NREQ);
        any  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux2_16.sv
// ----------------------------------------------------------------------------
// mux2_16: 16-bit 2:1 mux primitive (s=0 selects a).  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux2_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        s,
  output logic [15:0] y
);

  assign y = s ? b : a;

endmodule

`default_nettype wire

// File: rtl/bus_arbiter16.sv
// ----------------------------------------------------------------------------
// bus_arbiter16: round-robin bus arbiter with burst-hold fairness and mux tree.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_arbiter16
  import bus_arbiter16_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int DW       = ARB_DW,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DW-1:0]           data_in,
  input  logic                         out_ready,
  output logic [NREQ-1:0]              grant,
  output logic [clog2_min1(NREQ)-1:0]  sel,
  output logic [DW-1:0]                out_data,
  output logic                         out_valid,
  output logic                         busy
);

  localparam int SW = clog2_min1(NREQ);
  localparam int HW = clog2_min1(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t      state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [SW-1:0]   sel_nxt;
  logic [SW-1:0]   last, last_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [SW-1:0]   pick;
  logic            pick_any;
  logic            beat;
  logic            others_req;

  rr_picker #(.NREQ(NREQ), .SW(SW)) u_picker (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (pick_any)
  );

  assign out_valid  = (state == ARB_GRANT) & req[sel];
  assign busy       = (state == ARB_GRANT);
  assign beat       = out_valid & out_ready;
  assign others_req = |(req & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      sel      <= '0;
      last     <= SW'(NREQ - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt = ARB_GRANT;
          grant_nxt = NREQ'(1) << pick;
          sel_nxt   = pick;
          last_nxt  = pick;
          hold_nxt  = '0;
        end
      end
      ARB_GRANT: begin
        if (!req[sel]) begin
          state_nxt = ARB_IDLE;
          grant_nxt = '0;
        end else if (beat) begin
          if (hold_cnt == HOLD_LAST) begin
            // Burst limit reached: yield only if someone else is waiting.
            hold_nxt = '0;
            if (others_req) begin
              state_nxt = ARB_IDLE;
              grant_nxt = '0;
            end
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Heap-ordered mux tree: leaves at NREQ-1.., root at 0, MSB of sel at root.
  logic [DW-1:0] node [0:2*NREQ-2];

  for (genvar i = 0; i < NREQ; i++) begin : g_leaf
    assign node[NREQ-1+i] = data_in[i*DW +: DW];
  end

  for (genvar d = 0; d < SW; d++) begin : g_lvl
    for (genvar k = 0; k < (1 << d); k++) begin : g_node
      localparam int N = (1 << d) - 1 + k;
      mux2_16 u_mux (
        .a (node[2*N+1]),
        .b (node[2*N+2]),
        .s (sel[SW-1-d]),
        .y (node[N])
      );
    end
  end

  assign out_data = node[0];

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter16.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter16: vector table, directed corner sequences, random vs model.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter16;

  localparam int NREQ     = 4;
  localparam int DW       = 16;
  localparam int MAX_HOLD = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] data_in = '0;
  logic              out_ready = 1'b0;
  logic [NREQ-1:0]   grant;
  logic [1:0]        sel;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              busy;

  int passed = 0;
  int total  = 0;

  bus_arbiter16 #(.NREQ(NREQ), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit check_state);
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    if (check_state) begin
      check("reset_grant", 32'(grant), 32'h0);
      check("reset_sel",   32'(sel),   32'h0);
      check("reset_busy",  32'(busy),  32'h0);
      check("reset_valid", 32'(out_valid), 32'h0);
    end
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit                 rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic               rdy;
    logic [NREQ-1:0]    g;
    logic               v;
    logic [DW-1:0]      d;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(bit r, logic [3:0] q, logic [63:0] dd, logic rd,
                              logic [3:0] g, logic v, logic [15:0] d);
    vec_t t;
    t.rst = r; t.req = q; t.din = dd; t.rdy = rd; t.g = g; t.v = v; t.d = d;
    return t;
  endfunction

  // ---------------- reference model ----------------
  int m_owner, m_last, m_beats, m_sel;

  task automatic model_reset();
    m_owner = -1; m_last = NREQ - 1; m_beats = 0; m_sel = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic rdy);
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (r[c]) begin
          m_owner = c; m_last = c; m_sel = c; m_beats = 0;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (rdy) begin
      m_beats++;
      if (m_beats == MAX_HOLD) begin
        m_beats = 0;
        if ((r & ~(NREQ'(1) << m_owner)) != 0) m_owner = -1;
      end
    end
  endtask

  localparam logic [63:0] D4 = 64'h4444_3333_2222_1111;

  initial begin
    // Plain grant to requester 0, then 1111 with one-beat drops.
    tab.push_back(mk(1, 4'b0001, 64'h0000_0000_0000_AAAA, 1, 4'b0000, 0, 16'h0));
    for (int i = 0; i < 4; i++)
      tab.push_back(mk(0, 4'b0001, 64'h0000_0000_0000_AAAA, 1, 4'b0001, 1, 16'hAAAA));
    tab.push_back(mk(1, 4'b1111, D4, 1, 4'b0000, 0, 16'h0));
    tab.push_back(mk(0, 4'b1111, D4, 1, 4'b0001, 1, 16'h1111));
    tab.push_back(mk(0, 4'b1110, D4, 1, 4'b0001, 0, 16'h0));
    tab.push_back(mk(0, 4'b1110, D4, 1, 4'b0000, 0, 16'h0));
    tab.push_back(mk(0, 4'b1110, D4, 1, 4'b0010, 1, 16'h2222));
    tab.push_back(mk(0, 4'b1100, D4, 1, 4'b0010, 0, 16'h0));
    tab.push_back(mk(0, 4'b1100, D4, 1, 4'b0000, 0, 16'h0));
    tab.push_back(mk(0, 4'b1100, D4, 1, 4'b0100, 1, 16'h3333));
    tab.push_back(mk(0, 4'b1000, D4, 1, 4'b0100, 0, 16'h0));
    tab.push_back(mk(0, 4'b1000, D4, 1, 4'b0000, 0, 16'h0));
    tab.push_back(mk(0, 4'b1000, D4, 1, 4'b1000, 1, 16'h4444));
    tab.push_back(mk(0, 4'b0000, D4, 1, 4'b1000, 0, 16'h0));
    tab.push_back(mk(0, 4'b0000, D4, 1, 4'b0000, 0, 16'h0));

    @(negedge clk);
    do_reset(1'b1);

    foreach (tab[i]) begin
      if (tab[i].rst) do_reset(1'b0);
      req = tab[i].req;
      data_in = tab[i].din;
      out_ready = tab[i].rdy;
      #1;
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tab[i].g));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tab[i].v));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tab[i].g != 0 || tab[i].v));
      if (tab[i].v) check($sformatf("vec%0d_data", i), 32'(out_data), 32'(tab[i].d));
      tick();
    end

    // Forced yield after MAX_HOLD beats with requester 1 waiting.
    do_reset(1'b0);
    data_in = D4;
    req = 4'b0011;
    out_ready = 1'b1;
    tick();
    for (int b = 0; b < MAX_HOLD; b++) begin
      #1;
      check($sformatf("hold_beat%0d_grant", b), 32'(grant), 32'h1);
      check($sformatf("hold_beat%0d_valid", b), 32'(out_valid), 32'h1);
      tick();
    end
    #1 check("hold_yield_idle", 32'(grant), 32'h0);
    tick();
    #1 check("hold_next_owner", 32'(grant), 32'h2);
    check("hold_next_data", 32'(out_data), 32'h2222);

    // Lone requester keeps the bus across hold-counter wrap.
    do_reset(1'b0);
    req = 4'b0001;
    out_ready = 1'b1;
    tick();
    for (int b = 0; b < 20; b++) begin
      #1;
      check($sformatf("solo%0d_grant", b), 32'(grant), 32'h1);
      check($sformatf("solo%0d_valid", b), 32'(out_valid), 32'h1);
      tick();
    end

    // Stall: owner retained, data held.
    data_in = 64'h4444_3333_2222_1234;
    out_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      #1;
      check($sformatf("stall%0d_grant", b), 32'(grant), 32'h1);
      check($sformatf("stall%0d_valid", b), 32'(out_valid), 32'h1);
      check($sformatf("stall%0d_data", b), 32'(out_data), 32'h1234);
      tick();
    end
    out_ready = 1'b1;

    // Asynchronous reset in the middle of requester 2's burst.
    do_reset(1'b0);
    data_in = D4;
    req = 4'b0100;
    out_ready = 1'b1;
    tick();
    #1 check("mid_pre_grant", 32'(grant), 32'h4);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rel_idle", 32'(grant), 32'h0);
    tick();
    #1 check("mid_rel_grant", 32'(grant), 32'h4);

    // Randomized traffic against the reference model.
    do_reset(1'b0);
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [NREQ-1:0] eg;
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(15) == 0) req[i] = ~req[i];
      data_in = {$urandom, $urandom};
      out_ready = ($urandom_range(3) != 0);
      #1;
      eg = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
      check("rnd_grant", 32'(grant), 32'(eg));
      check("rnd_sel",   32'(sel),   32'(m_sel));
      check("rnd_busy",  32'(busy),  32'(m_owner >= 0));
      check("rnd_valid", 32'(out_valid), 32'(m_owner >= 0 && req[m_owner]));
      check("rnd_data",  32'(out_data), 32'(data_in[m_sel*DW +: DW]));
      @(posedge clk);
      model_step(req, out_ready);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
